// File: rtl/typhoon_pkg.sv
// rtl/typhoon_pkg.sv - shared framebuffer geometry, address packing, colour expansion, scan-out states
package typhoon_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} scanout_state_t;

  // What the colour outputs show after the most recent pixel strobe.
  typedef enum logic [1:0] {PIX_BLANK, PIX_FIFO, PIX_UNDERRUN} pix_sel_t;

  // Framebuffer word address; the writer uses the same packing.
  function automatic logic [19:0] fb_addr(input logic buf_sel, input logic [8:0] y,
                                          input logic [9:0] x);
    return {buf_sel, y, x};
  endfunction

  function automatic logic [23:0] rgb565_expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// rtl/scanout_fifo.sv - prefetch FIFO with flush, occupancy count and registered read data
module scanout_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [WIDTH-1:0]              wdata_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rdata_q;
  logic             do_push, do_pop;

  // A flush discards anything pushed or popped in the same cycle.
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != CW'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rdata_q  <= mem_q[rd_ptr_q];
      end
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;

endmodule

// File: rtl/scanout_reader.sv
// rtl/scanout_reader.sv - front-buffer prefetch from SRAM and VGA pixel output per pixel strobe
module scanout_reader
  import typhoon_pkg::*;
#(
  parameter int          H_ACTIVE       = DEF_H_ACTIVE,
  parameter int          V_ACTIVE       = DEF_V_ACTIVE,
  parameter int          V_TOTAL        = DEF_V_TOTAL,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [15:0] UNDERRUN_COLOR = 16'hF81F
) (
  input  logic        BOARD_CLK,
  input  logic        Reset_N,
  input  logic        pixelStrobe,
  input  logic [9:0]  VGA_SCAN_X,
  input  logic [9:0]  VGA_SCAN_Y,
  input  logic        doubleBuffer,
  output logic        queueRead,
  output logic [19:0] framebufferAddress,
  input  logic        DataReady,
  input  logic [15:0] DataFromSRAM,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        underrun,
  output logic        frontBuffer
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  scanout_state_t state_q, state_d;
  pix_sel_t       pix_sel_q, pix_sel_d;
  logic [9:0]     fx_q, fx_d, fy_q, fy_d;
  logic [19:0]    addr_q, addr_d;
  logic           front_q, front_d, req_q, req_d, underrun_q, underrun_d;
  logic           frame_start, in_active, last_px, push, pop;
  logic [CW-1:0]  fifo_count;
  logic [15:0]    fifo_rdata, pix_word;

  assign frame_start = (VGA_SCAN_Y == 10'(V_TOTAL - 1)) && (VGA_SCAN_X == '0);
  assign in_active   = (VGA_SCAN_X < 10'(H_ACTIVE)) && (VGA_SCAN_Y < 10'(V_ACTIVE));
  assign last_px     = (fx_q == 10'(H_ACTIVE - 1)) && (fy_q == 10'(V_ACTIVE - 1));

  always_comb begin
    state_d    = state_q;
    pix_sel_d  = pix_sel_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    addr_d     = addr_q;
    front_d    = front_q;
    req_d      = req_q;
    underrun_d = underrun_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (frame_start) begin
      front_d    = ~doubleBuffer;
      fx_d       = '0;
      fy_d       = '0;
      underrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE:  if (frame_start) state_d = FETCH;
      FETCH: begin
        if (!frame_start && (fifo_count != CW'(FIFO_DEPTH))) begin
          req_d   = 1'b1;
          addr_d  = fb_addr(front_q, fy_q[8:0], fx_q);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A read in flight across a frame boundary belongs to the old frame.
        if (frame_start) begin
          if (DataReady) begin
            req_d   = 1'b0;
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end else if (DataReady) begin
          push  = 1'b1;
          req_d = 1'b0;
          if (fx_q == 10'(H_ACTIVE - 1)) begin
            fx_d = '0;
            fy_d = fy_q + 10'd1;
          end else begin
            fx_d = fx_q + 10'd1;
          end
          state_d = last_px ? DONE : FETCH;
        end
      end
      DRAIN: begin
        if (DataReady) begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end
      DONE:    if (frame_start) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (pixelStrobe) begin
      if (!in_active) begin
        pix_sel_d = PIX_BLANK;
      end else if (fifo_count == '0) begin
        pix_sel_d  = PIX_UNDERRUN;
        underrun_d = 1'b1;
      end else begin
        pop       = 1'b1;
        pix_sel_d = PIX_FIFO;
      end
    end
  end

  always_ff @(posedge BOARD_CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= IDLE;
      pix_sel_q  <= PIX_BLANK;
      fx_q       <= '0;
      fy_q       <= '0;
      addr_q     <= '0;
      front_q    <= 1'b0;
      req_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_sel_q  <= pix_sel_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      addr_q     <= addr_d;
      front_q    <= front_d;
      req_q      <= req_d;
      underrun_q <= underrun_d;
    end
  end

  scanout_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk_i   (BOARD_CLK),
    .rst_ni  (Reset_N),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (frame_start),
    .wdata_i (DataFromSRAM),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  always_comb begin
    pix_word = 16'h0000;
    if (pix_sel_q == PIX_FIFO)          pix_word = fifo_rdata;
    else if (pix_sel_q == PIX_UNDERRUN) pix_word = UNDERRUN_COLOR;
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb565_expand(pix_word);
  assign queueRead          = req_q;
  assign framebufferAddress = addr_q;
  assign underrun           = underrun_q;
  assign frontBuffer        = front_q;

endmodule

// File: tb/tb_scanout_reader.sv
// tb/tb_scanout_reader.sv - self-checking bench for scanout_reader with a queue-based frame model
module tb_scanout_reader;

  localparam int HA = 640;
  localparam int VA = 4;
  localparam int VT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixelStrobe, doubleBuffer, queueRead, DataReady, underrun, frontBuffer;
  logic [9:0]  scan_x, scan_y;
  logic [19:0] framebufferAddress;
  logic [15:0] DataFromSRAM;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scanout_reader #(.H_ACTIVE(HA), .V_ACTIVE(VA), .V_TOTAL(VT), .FIFO_DEPTH(16),
                   .UNDERRUN_COLOR(16'hF81F)) dut (
    .BOARD_CLK(clk), .Reset_N(rst_n), .pixelStrobe(pixelStrobe),
    .VGA_SCAN_X(scan_x), .VGA_SCAN_Y(scan_y), .doubleBuffer(doubleBuffer),
    .queueRead(queueRead), .framebufferAddress(framebufferAddress),
    .DataReady(DataReady), .DataFromSRAM(DataFromSRAM),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .underrun(underrun), .frontBuffer(frontBuffer)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] fb_data(input logic [19:0] a);
    logic [18:0] i;
    i = a[18:0];
    if (i == 19'd0) return 16'hF800;
    if (i == 19'd1) return 16'h07E0;
    return i[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r, g, b;
    r = (int'(p) >> 11) & 31;
    g = (int'(p) >> 5) & 63;
    b = int'(p) & 31;
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  // SRAM arbiter: answers each request arb_lat cycles after it is first seen.
  int   arb_lat = 3;
  bit   arb_en  = 1'b1;
  int   arb_cnt = 0;
  initial begin
    DataReady    = 1'b0;
    DataFromSRAM = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        DataReady = 1'b0;
        arb_cnt   = 0;
      end else if (DataReady) begin
        DataReady = 1'b0;
        arb_cnt   = 0;
      end else if (queueRead && arb_en) begin
        if (arb_cnt >= arb_lat) begin
          DataReady    = 1'b1;
          DataFromSRAM = fb_data(framebufferAddress);
        end else begin
          arb_cnt++;
        end
      end
    end
  end

  // Frame model: the display sees exactly the front buffer's pixels in raster order.
  logic [15:0] m_q[$];
  logic        m_front, m_underrun, m_stale, prev_req, prev_dr;
  logic [23:0] exp_rgb;
  logic [19:0] m_req_addr, last_rise_addr, addr641;
  int          m_n, rise_cnt;

  always @(negedge clk) begin
    bit act, bnd;
    if (!rst_n) begin
      m_q.delete();
      m_front = 0; m_underrun = 0; m_stale = 0; prev_req = 0; prev_dr = 0;
      exp_rgb = '0; m_n = 0; m_req_addr = '0;
    end else begin
      chk("front", 32'(frontBuffer), 32'(m_front));
      chk("underrun", 32'(underrun), 32'(m_underrun));
      chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
      if (prev_req && !prev_dr) chk("req_hold", 32'(queueRead), 32'd1);
      if (queueRead && !prev_req) begin
        rise_cnt++;
        m_req_addr = {m_front, 9'(m_n / HA), 10'(m_n % HA)};
        chk("req_addr", 32'(framebufferAddress), 32'(m_req_addr));
        chk("req_space", 32'(m_q.size() < 16), 32'd1);
        chk("req_in_frame", 32'(m_n < HA * VA), 32'd1);
        m_stale = 0;
        last_rise_addr = framebufferAddress;
        if (rise_cnt == 641) addr641 = framebufferAddress;
      end
      act = pixelStrobe && (scan_x < 10'(HA)) && (scan_y < 10'(VA));
      bnd = (scan_y == 10'(VT - 1)) && (scan_x == 10'd0);
      if (pixelStrobe) begin
        if (!act) exp_rgb = '0;
        else if (m_q.size() == 0) begin
          exp_rgb    = expand(16'hF81F);
          m_underrun = 1'b1;
        end else exp_rgb = expand(m_q.pop_front());
      end
      if (DataReady && queueRead) begin
        if (!m_stale && !bnd) begin
          m_q.push_back(fb_data(m_req_addr));
          m_n++;
        end
        m_stale = 0;
      end
      if (bnd) begin
        m_q.delete();
        m_front    = ~doubleBuffer;
        m_n        = 0;
        m_underrun = 1'b0;
        if (queueRead && !DataReady) m_stale = 1'b1;
      end
      prev_req = queueRead;
      prev_dr  = DataReady;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic park();
    scan_x = 10'd700; scan_y = 10'd6;
  endtask

  task automatic boundary();
    scan_x = 10'd0; scan_y = 10'(VT - 1);
    tick();
    park();
  endtask

  task automatic strobe(input int x, input int y);
    scan_x = 10'(x); scan_y = 10'(y); pixelStrobe = 1'b1;
    tick();
    pixelStrobe = 1'b0;
    park();
  endtask

  task automatic wait_rise(input string nm);
    int k;
    k = 0;
    while (queueRead && k < 300) begin tick(); k++; end
    while (!queueRead && k < 300) begin tick(); k++; end
    chk({nm, "_timeout"}, 32'(k < 300), 32'd1);
  endtask

  initial begin
    int r0;
    rise_cnt = 0;
    rst_n = 1'b0; pixelStrobe = 1'b0; doubleBuffer = 1'b0; park();
    repeat (3) tick();
    chk("rst_req", 32'(queueRead), 0);
    chk("rst_addr", 32'(framebufferAddress), 0);
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_front", 32'(frontBuffer), 0);
    rst_n = 1'b1;
    tick();

    // Fill: no pops, FIFO tops out at 16 and requests stop.
    boundary();
    repeat (200) tick();
    chk("front_after_bnd", 32'(frontBuffer), 1);
    chk("fill_rises", 32'(rise_cnt), 16);
    chk("fill_idle_req", 32'(queueRead), 0);
    chk("first_addr", 32'(last_rise_addr) - 32'd15, 32'h80000);

    strobe(0, 0);
    chk("pix_red", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF0000);
    strobe(1, 0);
    chk("pix_green", 32'({VGA_R, VGA_G, VGA_B}), 32'h00FF00);

    for (int i = 2; i < HA + 10; i++) begin
      strobe(i % HA, i / HA);
      repeat (5) tick();
    end
    chk("addr_after_640", 32'(addr641), 32'h80400);
    chk("no_underrun_yet", 32'(underrun), 0);

    // Starve the FIFO while the display keeps popping.
    arb_en = 1'b0;
    for (int x = 0; x < 40; x++) begin
      scan_x = 10'(x); scan_y = 10'd2; pixelStrobe = 1'b1;
      tick();
    end
    pixelStrobe = 1'b0; park();
    chk("underrun_set", 32'(underrun), 1);
    chk("underrun_color", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF00FF);
    arb_en = 1'b1;

    // Mid-frame buffer swap, then a boundary landing on an outstanding read.
    doubleBuffer = 1'b1;
    repeat (5) tick();
    chk("front_held", 32'(frontBuffer), 1);
    arb_lat = 20;
    wait_rise("pre_drain");
    repeat (2) tick();
    boundary();
    chk("front_flipped", 32'(frontBuffer), 0);
    chk("underrun_cleared", 32'(underrun), 0);
    chk("drain_req_held", 32'(queueRead), 1);
    wait_rise("post_drain");
    chk("post_drain_addr", 32'(framebufferAddress), 32'h00000);
    repeat (60) tick();
    strobe(0, 0);
    chk("new_frame_pix0", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF0000);

    // Rest of the frame with a zero-latency arbiter.
    arb_lat = 0;
    for (int i = 1; i < HA * VA; i++) begin
      strobe(i % HA, i / HA);
      repeat (2) tick();
    end
    repeat (20) tick();
    chk("frame_pushes", 32'(m_n), 32'(HA * VA));
    chk("last_addr", 32'(last_rise_addr), 32'h00E7F);
    chk("done_idle", 32'(queueRead), 0);
    r0 = rise_cnt;
    repeat (100) tick();
    chk("done_no_req", 32'(rise_cnt - r0), 0);
    boundary();
    wait_rise("next_frame");
    chk("next_frame_addr", 32'(framebufferAddress), 32'h00000);

    // Reset with a request outstanding drops it without a clock.
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(queueRead), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_front", 32'(frontBuffer), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
